// File: rtl/crc_pkg.sv
// Shared types and defaults for the serial CRC-8 accumulator.
package crc_pkg;

  localparam int unsigned CRC_W = 8;

  localparam logic [CRC_W-1:0] CRC_POLY_DEF = 8'h07;
  localparam logic [CRC_W-1:0] CRC_INIT_DEF = 8'h00;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/crc8_step.sv
// Combinational one-bit CRC-8 update: one feedback XOR plus one XOR per set POLY bit.
module crc8_step
  import crc_pkg::*;
#(
  parameter logic [CRC_W-1:0] POLY = CRC_POLY_DEF
) (
  input  logic [CRC_W-1:0] crc_i,
  input  logic             bit_i,
  output logic [CRC_W-1:0] crc_next_o
);

  logic             fb;
  logic [CRC_W-1:0] shifted;

  assign fb      = crc_i[CRC_W-1] ^ bit_i;
  assign shifted = {crc_i[CRC_W-2:0], 1'b0};

  // Only taps with a set polynomial bit get an XOR; the rest are plain wires.
  for (genvar g = 0; g < CRC_W; g++) begin : g_tap
    if (POLY[g]) begin : g_xor
      assign crc_next_o[g] = shifted[g] ^ fb;
    end else begin : g_wire
      assign crc_next_o[g] = shifted[g];
    end
  end

endmodule

// File: rtl/crc8_serial_accumulator.sv
// Serial CRC-8 accumulator, MSB first, with one-cycle done pulse after FRAME_LEN bits.
// Optional: define CRC_FINAL_XOR_EN to present the remainder inverted on the crc port.
module crc8_serial_accumulator
  import crc_pkg::*;
#(
  parameter int unsigned      FRAME_LEN = 8,
  parameter logic [CRC_W-1:0] POLY      = CRC_POLY_DEF,
  parameter logic [CRC_W-1:0] INIT      = CRC_INIT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             bit_in,
  input  logic             bit_valid,
  output logic             busy,
  output logic             done,
  output logic [CRC_W-1:0] crc
);

  localparam logic [7:0] LAST_CNT = 8'(FRAME_LEN - 1);

  state_e           state_q, state_d;
  logic [CRC_W-1:0] crc_q, crc_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [CRC_W-1:0] crc_step;

  crc8_step #(
    .POLY(POLY)
  ) u_step (
    .crc_i     (crc_q),
    .bit_i     (bit_in),
    .crc_next_o(crc_step)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      crc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      crc_q   <= crc_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    crc_d   = crc_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          crc_d   = INIT;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (bit_valid) begin
          crc_d = crc_step;
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == LAST_CNT) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    busy = (state_q != IDLE);
    done = (state_q == DONE);
  end

`ifdef CRC_FINAL_XOR_EN
  assign crc = crc_q ^ '1;
`else
  assign crc = crc_q;
`endif

endmodule

// File: tb/tb_crc8_serial_accumulator.sv
// Randomized bench for crc8_serial_accumulator against a polynomial long-division model.
module tb_crc8_serial_accumulator;

  localparam logic [7:0] TB_POLY = 8'h07;
`ifdef CRC_FINAL_XOR_EN
  localparam logic [7:0] FX = 8'hFF;
`else
  localparam logic [7:0] FX = 8'h00;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0, bit_in = 1'b0, bit_valid = 1'b0;
  logic       busy, done;
  logic [7:0] crc;
  logic       start2 = 1'b0, bit2 = 1'b0, valid2 = 1'b0;
  logic       busy2, done2;
  logic [7:0] crc2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  crc8_serial_accumulator #(
    .FRAME_LEN(8),
    .POLY     (TB_POLY),
    .INIT     (8'h00)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .bit_in   (bit_in),
    .bit_valid(bit_valid),
    .busy     (busy),
    .done     (done),
    .crc      (crc)
  );

  crc8_serial_accumulator #(
    .FRAME_LEN(72),
    .POLY     (TB_POLY),
    .INIT     (8'h00)
  ) dut_long (
    .clk      (clk),
    .rst      (rst),
    .start    (start2),
    .bit_in   (bit2),
    .bit_valid(valid2),
    .busy     (busy2),
    .done     (done2),
    .crc      (crc2)
  );

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h at %0t", tag, got, exp, $time);
    end
  endtask

  // Remainder of M(x)*x^8 divided by G(x), done as textbook long division on a bit list.
  function automatic logic [7:0] ref_crc(input logic [127:0] msg, input int n);
    bit         q[$];
    logic [8:0] gen;
    logic [7:0] r;
    gen = {1'b1, TB_POLY};
    for (int i = n - 1; i >= 0; i--) q.push_back(msg[i]);
    repeat (8) q.push_back(1'b0);
    for (int i = 0; i < n; i++)
      if (q[i]) for (int j = 0; j < 9; j++) q[i+j] ^= gen[8-j];
    r = '0;
    for (int j = 0; j < 8; j++) r = {r[6:0], q[n+j]};
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sends one 8-bit frame; optional stray start at bit bad_start, optional reset before bit rst_at.
  task automatic run_frame8(input logic [7:0] data, input logic [7:0] exp, input int gapmax,
                            input int bad_start, input int rst_at);
    start     = 1'b1;
    bit_in    = 1'b1;
    bit_valid = 1'($urandom_range(0, 1));
    tick();
    start     = 1'b0;
    bit_valid = 1'b0;
    check("start_busy", {7'b0, busy}, 8'h01);
    check("start_crc_init", crc, 8'h00 ^ FX);
    for (int i = 0; i < 8; i++) begin
      repeat ($urandom_range(0, gapmax)) begin
        start = (i == bad_start);
        tick();
        start = 1'b0;
        check("gap_no_done", {7'b0, done}, 8'h00);
      end
      if (i == rst_at) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_crc", crc, 8'h00 ^ FX);
        check("midrst_busy", {7'b0, busy}, 8'h00);
        check("midrst_done", {7'b0, done}, 8'h00);
        tick();
        check("midrst_no_done", {7'b0, done}, 8'h00);
        return;
      end
      bit_in    = data[7-i];
      bit_valid = 1'b1;
      start     = (i == bad_start);
      tick();
      bit_valid = 1'b0;
      start     = 1'b0;
      if (i < 7) begin
        check("bit_no_done", {7'b0, done}, 8'h00);
      end else begin
        check("last_done", {7'b0, done}, 8'h01);
        check("last_busy", {7'b0, busy}, 8'h01);
        check("last_crc", crc, exp ^ FX);
      end
    end
    tick();
    check("after_done", {7'b0, done}, 8'h00);
    check("after_busy", {7'b0, busy}, 8'h00);
    check("after_crc_hold", crc, exp ^ FX);
  endtask

  task automatic run_long(input logic [71:0] m, input logic [7:0] exp);
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    check("long_busy", {7'b0, busy2}, 8'h01);
    for (int i = 0; i < 72; i++) begin
      repeat ($urandom_range(0, 2)) tick();
      bit2   = m[71-i];
      valid2 = 1'b1;
      tick();
      valid2 = 1'b0;
      if (i < 71) begin
        if (done2 !== 1'b0) check("long_early_done", {7'b0, done2}, 8'h00);
      end else begin
        check("long_done", {7'b0, done2}, 8'h01);
      end
    end
    check("long_crc", crc2, exp ^ FX);
    check("long_crc_model", crc2, ref_crc({56'b0, m}, 72) ^ FX);
    tick();
    check("long_after_done", {7'b0, done2}, 8'h00);
    check("long_after_busy", {7'b0, busy2}, 8'h00);
  endtask

  initial begin
    logic [7:0]  d;
    logic [71:0] msg;
    int          bs, ra;

    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("rst_crc", crc, 8'h00 ^ FX);
    check("rst_done", {7'b0, done}, 8'h00);
    check("rst_busy", {7'b0, busy}, 8'h00);
    check("rst_crc_long", crc2, 8'h00 ^ FX);
    tick();

    run_frame8(8'h31, 8'h97, 0, -1, -1);
    run_frame8(8'h31, 8'h97, 3, -1, -1);
    run_frame8(8'h31, 8'h97, 1, 3, -1);
    run_frame8(8'h00, 8'h00, 1, -1, -1);
    run_frame8(8'h31, 8'h00, 0, -1, 5);
    run_frame8(8'h31, 8'h97, 0, -1, -1);
    check("model_sanity", ref_crc(128'h31, 8), 8'h97);

    msg = "123456789";
    run_long(msg, 8'hF4);

    for (int k = 0; k < 40; k++) begin
      d  = 8'($urandom);
      bs = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : -1;
      ra = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 7)) : -1;
      run_frame8(d, ref_crc({120'b0, d}, 8), int'($urandom_range(0, 3)), bs, ra);
      repeat ($urandom_range(0, 2)) tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/crc8_serial_accumulator.md
# crc8_serial_accumulator

Serial CRC-8 accumulator that sits directly downstream of the team's XOR/NAND gate cells. It consumes a bit-serial data stream, one bit per accepted cycle, MSB first, and folds each bit into an 8-bit remainder through a feedback network built from XOR cells. After a programmed number of bits it presents the final CRC with a one-cycle done pulse. It is the first clocked consumer of the gate library and is used as the checksum stage for serial test frames.

## Interface
- FRAME_LEN, 8: bits per frame; legal range 1..255.
- POLY, 8'h07: generator polynomial, implicit x^8 term.
- INIT, 8'h00: remainder loaded on start.
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-high.
- start  input  1  begin a new frame; sampled in IDLE only.
- bit_in  input  1  serial data bit, MSB first.
- bit_valid  input  1  bit_in is presented this cycle.
- busy  output  1  high in SHIFT and DONE.
- done  output  1  one-cycle pulse; crc is final while high.
- crc  output  8  current remainder; holds its value after done.

## Operation
- States:
  - IDLE: wait for start.
  - SHIFT: accumulate bits.
  - DONE: one cycle, then back to IDLE.
- IDLE with start=1 → load remainder with INIT, clear bit count to 0, go to SHIFT. bit_valid is ignored in IDLE.
- SHIFT with bit_valid=1:
  - fb = crc[7] XOR bit_in.
  - crc ← {crc[6:0],0} XOR (fb ? POLY : 0).
  - count increments.
- SHIFT with bit_valid=0: no change. Gaps of any length are legal.
- Last accepted bit (count = FRAME_LEN-1 with bit_valid=1) → update crc, go to DONE.
- DONE: done=1 for exactly one cycle, crc frozen, then IDLE.
- start while busy: ignored. No restart and no queueing.
- start and bit_valid in the same IDLE cycle: the bit is dropped. The first counted bit is the first valid bit in SHIFT.
- Bit counter: 8-bit unsigned, never wraps. FRAME_LEN bounds it.
- rst in any state, including mid-frame:
  - next state IDLE
  - crc=8'h00
  - count=0
  - done=0
  - busy=0
  - The partial frame is discarded.

## Timing
- Reset values: crc=8'h00, done=0, busy=0.
- start sampled at edge N → busy=1 from N+1, and crc=INIT at N+1.
- Each valid bit sampled at an edge updates crc at that same edge.
- Final valid bit sampled at edge M → done=1 and busy=1 during cycle M..M+1. At edge M+1: done=0, busy=0.
- Minimum frame time: FRAME_LEN+2 cycles from start to IDLE.
- A new start is accepted no earlier than the cycle after done.

## Configuration
- CRC_FINAL_XOR_EN defined: the crc output port shows remainder XOR 8'hFF in all states. The internal remainder is unaffected, and the reset output value becomes 8'hFF.
- CRC_FINAL_XOR_EN undefined: the crc port shows the raw remainder.

## Structure
- Shared package crc_pkg:
  - state enum {IDLE, SHIFT, DONE}
  - CRC_W=8
  - default POLY and INIT constants
- Sub-module crc8_step: combinational one-bit update (crc, bit_in, POLY → crc_next). Built from the team's XOR gate cells, one per set POLY bit plus one feedback XOR.
- The top module holds the state register, bit counter and remainder register.

## Test plan
- Reset check: assert rst for 2 cycles → crc=8'h00, done=0, busy=0. With CRC_FINAL_XOR_EN defined, crc=8'hFF instead.
- Single byte: start, then bits of 8'h31 MSB first with no gaps → done after the 8th bit, crc=8'h97. With CRC_FINAL_XOR_EN defined, crc=8'h68.
- Gaps: same 8'h31 with bit_valid=0 inserted between every bit → crc=8'h97, done only after the 8th valid bit.
- Long frame: FRAME_LEN=72, ASCII "123456789" → crc=8'hF4.
- Start while busy: pulse start at bit 3 → ignored, result still 8'h97. An all-zero byte with INIT=0 → crc=8'h00.
- Reset mid-frame: rst at bit 5 → IDLE, crc=8'h00, no done. The next full frame of 8'h31 → 8'h97.
